msi_fab_add_drop: RTL and testbench

MSI_FAB_ADD_DROP -- requirements
Module: msi_fab_add_drop

---
 rtl/msi_fab_add_drop.sv | 117 +++++++++++
 tb/tb_msi_fab_add_drop.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/msi_fab_add_drop.sv
`default_nettype none
// ============================================================================
// Module   : msi_fab_add_drop
// Purpose  : Ring-stop add/drop for an 80-bit fabric word. Words addressed to
//            NODE_ID are dropped to the cluster. Cluster words are queued in a
//            small add FIFO and inserted into free ring slots. Optional orphan
//            purge is enabled by defining the macro MSI_FAB_PURGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module msi_fab_add_drop #(
    parameter logic [3:0] NODE_ID    = 4'h2,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [79:0] ring_in,
    output logic [79:0] ring_out,
    output logic [79:0] fab_drop_bus80,
    input  logic [79:0] fab_add_bus80,
    output logic        add_ready,
    output logic        purge_pulse
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(FIFO_DEPTH - 1);

    logic [79:0]        mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [79:0]        ring_out_q, ring_out_d;
    logic [79:0]        drop_q, drop_d;

    logic w_valid, w_dest_hit, w_drop, w_purge, w_free, w_pop, w_push;

    assign w_valid    = ring_in[79];
    assign w_dest_hit = (ring_in[78:75] == NODE_ID);
    assign w_drop     = w_valid && w_dest_hit;

`ifdef MSI_FAB_PURGE_EN
    // A word we sourced that comes back around undelivered is an orphan.
    logic purge_q;

    assign w_purge = w_valid && !w_dest_hit && (ring_in[74:71] == NODE_ID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            purge_q <= 1'b0;
        end else begin
            purge_q <= w_purge;
        end
    end

    assign purge_pulse = purge_q;
`else
    assign w_purge     = 1'b0;
    assign purge_pulse = 1'b0;
`endif

    assign w_free    = !w_valid || w_drop || w_purge;
    assign add_ready = (count_q < c_DEPTH);
    assign w_pop     = w_free && (count_q != '0);
    assign w_push    = fab_add_bus80[79] && add_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ring_out_d = ring_in;
        drop_d     = w_drop ? ring_in : '0;

        if (w_free) begin
            ring_out_d = w_pop ? mem_q[rd_ptr_q] : '0;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; validity lives entirely in the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= fab_add_bus80;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ring_out_q <= '0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ring_out_q <= ring_out_d;
            drop_q     <= drop_d;
        end
    end

    assign ring_out       = ring_out_q;
    assign fab_drop_bus80 = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_msi_fab_add_drop.sv
`default_nettype none
// ============================================================================
// Module   : tb_msi_fab_add_drop
// Purpose  : Scoreboard bench for msi_fab_add_drop (NODE_ID=2, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_msi_fab_add_drop;

`ifdef MSI_FAB_PURGE_EN
    localparam bit c_PURGE = 1'b1;
`else
    localparam bit c_PURGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [79:0] ring_in = '0;
    logic [79:0] fab_add_bus80 = '0;
    logic [79:0] ring_out;
    logic [79:0] fab_drop_bus80;
    logic        add_ready;
    logic        purge_pulse;

    msi_fab_add_drop #(
        .NODE_ID   (4'h2),
        .FIFO_DEPTH(4)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ring_in       (ring_in),
        .ring_out      (ring_out),
        .fab_drop_bus80(fab_drop_bus80),
        .fab_add_bus80 (fab_add_bus80),
        .add_ready     (add_ready),
        .purge_pulse   (purge_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] ring;
        logic [79:0] drop;
        logic        purge;
        logic        rdy;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   sid    = 0;

    function automatic logic [79:0] wd(input logic [3:0] d, input logic [3:0] s,
                                       input logic [6:0] t, input logic [63:0] p);
        return {1'b1, d, s, t, p};
    endfunction

    task automatic check(input string nm, input int id, input logic [79:0] got,
                         input logic [79:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h required %h", nm, id, got, exp);
    endtask

    task automatic step(input logic [79:0] r, input logic [79:0] a,
                        input logic [79:0] er, input logic [79:0] ed,
                        input logic ep, input logic erdy);
        exp_t e;
        @(negedge clk);
        ring_in       = r;
        fab_add_bus80 = a;
        e.ring = er; e.drop = ed; e.purge = ep; e.rdy = erdy; e.id = sid;
        q.push_back(e);
        sid++;
    endtask

    task automatic reset_check(input int id);
        check("rst_ring_out", id, ring_out, '0);
        check("rst_drop", id, fab_drop_bus80, '0);
        check("rst_purge", id, {79'd0, purge_pulse}, '0);
    endtask

    // Monitor: compares one expected response per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("ring_out", e.id, ring_out, e.ring);
            check("drop", e.id, fab_drop_bus80, e.drop);
            check("purge", e.id, {79'd0, purge_pulse}, {79'd0, e.purge});
            check("add_ready", e.id, {79'd0, add_ready}, {79'd0, e.rdy});
        end
    end

    logic [79:0] dw, fw, lw, d2, pw, ew;
    logic [79:0] a_w [1:4];
    logic [79:0] b_w [1:5];
    logic [79:0] f_w [1:10];
    logic [79:0] c_w [1:3];

    initial begin
        dw = wd(4'h2, 4'h3, 7'h09, 64'hA5);
        fw = wd(4'h5, 4'h3, 7'h11, 64'h1234);
        lw = wd(4'h2, 4'h2, 7'h20, 64'h2020);
        d2 = wd(4'h2, 4'h6, 7'h40, 64'hD2);
        pw = wd(4'h7, 4'h2, 7'h50, 64'h5050);
        ew = wd(4'h4, 4'h2, 7'h70, 64'hE);
        for (int k = 1; k <= 4; k++)  a_w[k] = wd(4'h5, 4'h2, 7'(k), 64'(256 + k));
        for (int k = 1; k <= 5; k++)  b_w[k] = wd(4'h5, 4'h2, 7'(48 + k), 64'(2816 + k));
        for (int k = 1; k <= 10; k++) f_w[k] = wd(4'h5, 4'h3, 7'(96 + k), 64'(3840 + k));
        for (int k = 1; k <= 3; k++)  c_w[k] = wd(4'h5, 4'h2, 7'(112 + k), 64'(3072 + k));

        #12;
        reset_check(-1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, drop, forward
        step('0, '0, '0, '0, 1'b0, 1'b1);
        step(dw, '0, '0, dw, 1'b0, 1'b1);
        step(fw, '0, fw, '0, 1'b0, 1'b1);

        // Four pushes on an idle ring come out back-to-back in order
        step('0, a_w[1], '0, '0, 1'b0, 1'b1);
        step('0, a_w[2], a_w[1], '0, 1'b0, 1'b1);
        step('0, a_w[3], a_w[2], '0, 1'b0, 1'b1);
        step('0, a_w[4], a_w[3], '0, 1'b0, 1'b1);
        step('0, '0, a_w[4], '0, 1'b0, 1'b1);
        step('0, '0, '0, '0, 1'b0, 1'b1);

        // Locally addressed add word goes out on the ring, no loopback
        step('0, lw, '0, '0, 1'b0, 1'b1);
        step('0, '0, lw, '0, 1'b0, 1'b1);

        // Saturated ring fills FIFO; full FIFO holds fifth word
        step(f_w[1], b_w[1], f_w[1], '0, 1'b0, 1'b1);
        step(f_w[2], b_w[2], f_w[2], '0, 1'b0, 1'b1);
        step(f_w[3], b_w[3], f_w[3], '0, 1'b0, 1'b1);
        step(f_w[4], b_w[4], f_w[4], '0, 1'b0, 1'b0);
        step(f_w[5], b_w[5], f_w[5], '0, 1'b0, 1'b0);
        step('0, b_w[5], b_w[1], '0, 1'b0, 1'b1);
        step(f_w[6], b_w[5], f_w[6], '0, 1'b0, 1'b0);
        step('0, '0, b_w[2], '0, 1'b0, 1'b1);
        step(d2, '0, b_w[3], d2, 1'b0, 1'b1);

        // Orphan word sourced here, addressed elsewhere
        step(pw, '0, c_PURGE ? b_w[4] : pw, '0, c_PURGE, 1'b1);
        step('0, '0, c_PURGE ? b_w[5] : b_w[4], '0, 1'b0, 1'b1);
        step('0, '0, c_PURGE ? 80'd0 : b_w[5], '0, 1'b0, 1'b1);

        // Three words held, then reset mid-cycle
        step(f_w[7], c_w[1], f_w[7], '0, 1'b0, 1'b1);
        step(f_w[8], c_w[2], f_w[8], '0, 1'b0, 1'b1);
        step(f_w[9], c_w[3], f_w[9], '0, 1'b0, 1'b1);
        step(f_w[10], '0, f_w[10], '0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_check(-2);
        ring_in       = '0;
        fab_add_bus80 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step('0, '0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, '0, 1'b0, 1'b1);
        step('0, ew, '0, '0, 1'b0, 1'b1);
        step('0, '0, ew, '0, 1'b0, 1'b1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_tot++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
